// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage: PC select codes,
// the NOP encoding, fault causes and the fetch FSM state encoding.
package riscv_pkg;
  localparam logic [1:0]  PC_ALU    = 2'd0;
  localparam logic [1:0]  PC_PLUS_4 = 2'd1;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_BUS      = 2'd2
  } faultCause_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetchState_t;
endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection from execute feedback; a taken branch overrides pc_sel.
module next_pc_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  logic takeAlu;

  assign takeAlu = (pc_sel == PC_ALU) || br_taken;
  // Bit 0 of a jump target is always dropped; only bit 1 can misalign.
  assign next_pc = takeAlu ? {alu_target[XLEN-1:1], 1'b0} : pc + XLEN'(4);
  assign misaligned = |next_pc[1:0];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request per
// instruction, holds the fetched word until retire and traps faults.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic [1:0]      pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_target,
  output logic            fault,
  output logic [1:0]      fault_cause
);
  fetchState_t     state;
  faultCause_t     causeQ;
  logic [XLEN-1:0] pc, nextPc;
  logic [31:0]     instQ;
  logic            misaligned, reqQ, validQ, faultQ;

  next_pc_gen #(.XLEN(XLEN)) u_nextPc (
    .pc         (pc),
    .pc_sel     (pc_sel),
    .br_taken   (br_taken),
    .alu_target (alu_target),
    .next_pc    (nextPc),
    .misaligned (misaligned)
  );

  // reqQ lags entry into S_REQ after reset by one cycle, so imem_ready is
  // only honoured once the request is actually visible on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      reqQ   <= 1'b0;
      validQ <= 1'b0;
      instQ  <= NOP_INST;
      faultQ <= 1'b0;
      causeQ <= FC_NONE;
    end else begin
      case (state)
        S_REQ: begin
          if (reqQ && imem_ready) begin
            reqQ  <= 1'b0;
            state <= S_WAIT;
          end else begin
            reqQ <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (imem_err) begin
              faultQ <= 1'b1;
              causeQ <= FC_BUS;
              state  <= S_FAULT;
            end else begin
              instQ  <= imem_rdata;
              validQ <= 1'b1;
              state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            validQ <= 1'b0;
            if (misaligned) begin
              faultQ <= 1'b1;
              causeQ <= FC_MISALIGN;
              state  <= S_FAULT;
            end else begin
              pc    <= nextPc;
              reqQ  <= 1'b1;
              state <= S_REQ;
            end
          end
        end
        default: begin
          reqQ   <= 1'b0;
          validQ <= 1'b0;
          state  <= S_FAULT;
        end
      endcase
    end
  end

  assign imem_req    = reqQ;
  assign imem_addr   = pc;
  assign inst        = instQ;
  assign inst_pc     = pc;
  assign inst_pc4    = pc + XLEN'(4);
  assign inst_valid  = validQ;
  assign fault       = faultQ;
  assign fault_cause = causeQ;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit; expected PCs come from a
// small arithmetic model of the next-PC and fault rules.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc, inst_pc4, alu_target;
  logic        inst_valid, inst_ready, br_taken, fault;
  logic [1:0]  pc_sel, fault_cause;

  int          nCmp = 0;
  int          nErr = 0;
  logic [31:0] expPc;
  logic        faulted;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc_sel(pc_sel), .br_taken(br_taken),
    .alu_target(alu_target), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_addr", imem_addr, 0);
    rst_n = 1'b1;
    expPc = 32'h0;
    tick();
    chk("req_after_rst", imem_req, 1);
  endtask

  // One fetch transaction with programmable ready and response latency.
  task automatic doFetch(input logic [31:0] data, input int rdyWait, input int rvWait,
                         input logic err);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_asserted", imem_req, 1);
    chk("fetch_addr", imem_addr, expPc);
    for (int i = 0; i < rdyWait; i++) begin
      tick();
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, expPc);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("req_drop", imem_req, 0);
    for (int i = 0; i < rvWait; i++) begin
      tick();
      chk("wait_no_valid", inst_valid, 0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    imem_err    = err;
    tick();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = $urandom;
    if (err) begin
      chk("buserr_fault", fault, 1);
      chk("buserr_cause", fault_cause, 2);
      chk("buserr_valid", inst_valid, 0);
      tick();
      chk("buserr_req", imem_req, 0);
    end else begin
      chk("inst_valid", inst_valid, 1);
      chk("inst", inst, data);
      chk("inst_pc", inst_pc, expPc);
      chk("inst_pc4", inst_pc4, expPc + 32'd4);
    end
  endtask

  // Retire the held instruction; the model applies the next-PC rule directly.
  task automatic retire(input logic [1:0] sel, input logic br, input logic [31:0] tgt,
                        output logic didFault);
    logic [31:0] nxt;
    nxt = (sel == 2'd0 || br) ? (tgt & 32'hFFFF_FFFE) : expPc + 32'd4;
    inst_ready = 1'b1;
    pc_sel     = sel;
    br_taken   = br;
    alu_target = tgt;
    tick();
    inst_ready = 1'b0;
    pc_sel     = 2'($urandom);
    br_taken   = 1'($urandom);
    alu_target = $urandom;
    chk("retire_valid", inst_valid, 0);
    didFault = (nxt % 4) != 0;
    if (didFault) begin
      chk("mis_fault", fault, 1);
      chk("mis_cause", fault_cause, 1);
      chk("mis_req", imem_req, 0);
      chk("mis_pc", imem_addr, expPc);
      repeat (3) tick();
      chk("fault_sticky", fault, 1);
      chk("fault_req", imem_req, 0);
      chk("fault_valid", inst_valid, 0);
    end else begin
      expPc = nxt;
      chk("retire_req", imem_req, 1);
      chk("retire_addr", imem_addr, expPc);
      chk("retire_nofault", fault, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; pc_sel = 2'd1; br_taken = 1'b0;
    alu_target = '0; expPc = '0;
    repeat (3) tick();
    resetPulse();

    // First instruction, best case latency.
    doFetch(32'h0050_0093, 0, 0, 1'b0);
    retire(2'd0, 1'b0, 32'h100, faulted);
    doFetch(32'h1111_1111, 1, 0, 1'b0);
    retire(2'd1, 1'b0, 32'h0, faulted);
    chk("seq_104", imem_addr, 32'h104);
    doFetch(32'h2222_2222, 0, 2, 1'b0);
    retire(2'd1, 1'b1, 32'h80, faulted);
    chk("br_80", imem_addr, 32'h80);
    doFetch(32'h3333_3333, 0, 0, 1'b0);
    retire(2'd0, 1'b0, 32'h201, faulted);
    chk("jmp_200", imem_addr, 32'h200);

    // inst_ready outside S_HOLD must not move the PC.
    inst_ready = 1'b1; pc_sel = 2'd0; alu_target = 32'h44; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("ign_ready_req", imem_req, 0);
    chk("ign_ready_addr", imem_addr, expPc);
    tick();
    inst_ready = 1'b0;
    chk("ign_ready_wait", imem_addr, expPc);
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    imem_rvalid = 1'b0;
    chk("ign_ready_valid", inst_valid, 1);
    chk("ign_ready_pc", inst_pc, 32'h200);

    retire(2'd0, 1'b0, 32'h102, faulted);
    chk("mis_expected", faulted, 1);
    resetPulse();

    // ready and rvalid together in S_REQ: only the acceptance counts.
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    chk("both_req", imem_req, 0);
    chk("both_valid", inst_valid, 0);
    tick();
    chk("both_still_wait", inst_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_1234;
    tick();
    imem_rvalid = 1'b0;
    chk("both_inst", inst, 32'h0000_1234);
    chk("both_valid2", inst_valid, 1);
    retire(2'd1, 1'b0, 32'h0, faulted);

    // Stalled acceptance followed by a bus error.
    doFetch(32'h5555_5555, 5, 2, 1'b1);
    resetPulse();

    // Reset in S_WAIT, then a stale response after release.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("abort_req", imem_req, 0);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_valid", inst_valid, 0);
    chk("stale_req", imem_req, 1);
    chk("stale_addr", imem_addr, 32'h0);
    tick();
    chk("stale_valid2", inst_valid, 0);
    expPc = 32'h0;
    doFetch(32'hCAFE_0013, 1, 1, 1'b0);

    // PC wrap at the top of the address space.
    retire(2'd0, 1'b0, 32'hFFFF_FFFC, faulted);
    doFetch(32'h6666_6666, 0, 0, 1'b0);
    retire(2'd1, 1'b0, 32'h0, faulted);
    chk("wrap_zero", imem_addr, 32'h0);
    doFetch(32'h7777_7777, 0, 1, 1'b0);

    // Randomized retire/fetch traffic.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] tgt;
      logic        err;
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt = tgt & 32'hFFFF_FFFC;
      retire(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, tgt, faulted);
      if (faulted) resetPulse();
      err = $urandom_range(0, 11) == 0;
      doFetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), err);
      if (err) begin
        resetPulse();
        doFetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
